// File: rtl/tag_probe_issue.sv
// DRAM cache front end: arbitrates host AXI reads/writes and issues one tag+data probe per request,
// pushing the matching Tag FIFO entry, ROB ID record or write-buffer entry on the probe handshake.
module tag_probe_issue #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 512,
  parameter int ID_WIDTH     = 4,
  parameter int INDEX_WIDTH  = 14,
  parameter int OFFSET_WIDTH = 6,
  parameter int TID_WIDTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ID_WIDTH-1:0]             arid_i,
  input  logic [ADDR_WIDTH-1:0]           araddr_i,
  input  logic                            arvalid_i,
  output logic                            arready_o,
  input  logic [ID_WIDTH-1:0]             awid_i,
  input  logic [ADDR_WIDTH-1:0]           awaddr_i,
  input  logic                            awvalid_i,
  output logic                            awready_o,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic                            wvalid_i,
  output logic                            wready_o,
  output logic [ID_WIDTH-1:0]             bid_o,
  output logic                            bvalid_o,
  input  logic                            bready_i,
  output logic [ADDR_WIDTH-1:0]           mc_araddr_o,
  output logic                            mc_arvalid_o,
  input  logic                            mc_arready_i,
  input  logic                            tag_fifo_afull_i,
  output logic                            tag_fifo_wren_o,
  output logic [TID_WIDTH+ADDR_WIDTH:0]   tag_fifo_data_o,
  input  logic                            wbuffer_afull_i,
  output logic                            wbuffer_wren_o,
  output logic [DATA_WIDTH-1:0]           wbuffer_data_o,
  output logic                            rob_id_wren_o,
  output logic [TID_WIDTH-1:0]            rob_id_tid_o,
  output logic [ID_WIDTH-1:0]             rob_id_o,
  input  logic                            rob_retire_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  localparam logic [TID_WIDTH:0]   CREDIT_FULL = {1'b1, {TID_WIDTH{1'b0}}};
  localparam logic [TID_WIDTH:0]   CREDIT_ONE  = 1;
  localparam logic [TID_WIDTH-1:0] TID_ONE     = 1;
  // Probe keeps only the set index bits; tag and line offset are zeroed.
  localparam logic [ADDR_WIDTH-1:0] INDEX_MASK =
    ((ADDR_WIDTH'(1) << INDEX_WIDTH) - ADDR_WIDTH'(1)) << OFFSET_WIDTH;

  logic [1:0]            state;
  logic                  last_wr;
  logic [TID_WIDTH-1:0]  tid_cnt;
  logic [TID_WIDTH:0]    credits;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic idle, probing, rd_elig, wr_elig, grant_rd, grant_wr, alloc;

  always_comb begin
    idle     = (state == S_IDLE);
    probing  = (state == S_RD) || (state == S_WR);
    rd_elig  = arvalid_i && (credits != '0) && !tag_fifo_afull_i;
    wr_elig  = awvalid_i && wvalid_i && !tag_fifo_afull_i && !wbuffer_afull_i;
    // Contention goes to the kind that did not win last time.
    grant_rd = idle && rd_elig && (!wr_elig || last_wr);
    grant_wr = idle && wr_elig && !grant_rd;
    alloc    = (state == S_RD) && mc_arready_i;
  end

  assign arready_o       = grant_rd;
  assign awready_o       = grant_wr;
  assign wready_o        = grant_wr;
  assign mc_arvalid_o    = probing;
  assign mc_araddr_o     = addr_q & INDEX_MASK;
  assign tag_fifo_wren_o = probing && mc_arready_i;
  assign tag_fifo_data_o = (state == S_WR) ? {1'b1, {TID_WIDTH{1'b0}}, addr_q}
                                           : {1'b0, tid_cnt, addr_q};
  assign wbuffer_wren_o  = (state == S_WR) && mc_arready_i;
  assign wbuffer_data_o  = wdata_q;
  assign rob_id_wren_o   = alloc;
  assign rob_id_tid_o    = tid_cnt;
  assign rob_id_o        = id_q;
  assign bvalid_o        = (state == S_B);
  assign bid_o           = id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      last_wr <= 1'b1;
      tid_cnt <= '0;
      credits <= CREDIT_FULL;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_rd)      state <= S_RD;
          else if (grant_wr) state <= S_WR;
        end
        S_RD:    if (mc_arready_i) state <= S_IDLE;
        S_WR:    if (mc_arready_i) state <= S_B;
        S_B:     if (bready_i)     state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (grant_rd) begin
        id_q    <= arid_i;
        addr_q  <= araddr_i;
        last_wr <= 1'b0;
      end else if (grant_wr) begin
        id_q    <= awid_i;
        addr_q  <= awaddr_i;
        wdata_q <= wdata_i;
        last_wr <= 1'b1;
      end

      if (alloc) tid_cnt <= tid_cnt + TID_ONE;

      // A retire arriving at full credit is spurious and dropped.
      if (alloc && !rob_retire_i)
        credits <= credits - CREDIT_ONE;
      else if (!alloc && rob_retire_i && (credits != CREDIT_FULL))
        credits <= credits + CREDIT_ONE;
    end
  end

endmodule

// File: tb/tb_tag_probe_issue.sv
// Bench for tag_probe_issue: directed scenarios plus a randomized run against a transaction-level model.
module tb_tag_probe_issue;
  localparam int AW = 64, DW = 512, IW = 4, XW = 14, OW = 6, TW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [IW-1:0] arid_i, awid_i, bid_o, rob_id_o;
  logic [AW-1:0] araddr_i, awaddr_i, mc_araddr_o;
  logic [DW-1:0] wdata_i, wbuffer_data_o;
  logic arvalid_i, arready_o, awvalid_i, awready_o, wvalid_i, wready_o;
  logic bvalid_o, bready_i, mc_arvalid_o, mc_arready_i;
  logic tag_fifo_afull_i, tag_fifo_wren_o, wbuffer_afull_i, wbuffer_wren_o;
  logic rob_id_wren_o, rob_retire_i;
  logic [TW+AW:0] tag_fifo_data_o;
  logic [TW-1:0] rob_id_tid_o;

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] mtid;
  int mcred;
  bit mlast_wr;

  always #5 clk = ~clk;

  tag_probe_issue dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .mc_araddr_o(mc_araddr_o), .mc_arvalid_o(mc_arvalid_o), .mc_arready_i(mc_arready_i),
    .tag_fifo_afull_i(tag_fifo_afull_i), .tag_fifo_wren_o(tag_fifo_wren_o),
    .tag_fifo_data_o(tag_fifo_data_o),
    .wbuffer_afull_i(wbuffer_afull_i), .wbuffer_wren_o(wbuffer_wren_o),
    .wbuffer_data_o(wbuffer_data_o),
    .rob_id_wren_o(rob_id_wren_o), .rob_id_tid_o(rob_id_tid_o), .rob_id_o(rob_id_o),
    .rob_retire_i(rob_retire_i)
  );

  // Set index extracted arithmetically and placed back at its bit position.
  function automatic logic [AW-1:0] probe(input logic [AW-1:0] a);
    return ((a >> OW) % (64'd1 << XW)) << OW;
  endfunction

  task automatic clr();
    arvalid_i = 0; awvalid_i = 0; wvalid_i = 0; mc_arready_i = 0; bready_i = 0;
    tag_fifo_afull_i = 0; wbuffer_afull_i = 0; rob_retire_i = 0;
    arid_i = '0; awid_i = '0; araddr_i = '0; awaddr_i = '0; wdata_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clr();
    tick();
    tick();
    checks++;
    if ({arready_o, awready_o, wready_o, bvalid_o, bid_o, mc_araddr_o, mc_arvalid_o,
         tag_fifo_wren_o, tag_fifo_data_o, wbuffer_wren_o, wbuffer_data_o,
         rob_id_wren_o, rob_id_tid_o, rob_id_o} !== '0)
      begin errors++; $display("FAIL reset_outputs: some output nonzero (bvalid=%b mc_arvalid=%b tag=%h) required all 0", bvalid_o, mc_arvalid_o, tag_fifo_data_o); end
    rst_n = 1;
    mtid = 0; mcred = 16; mlast_wr = 1;
    tick();
  endtask

  task automatic test_single_read();
    logic [AW-1:0] a;
    a = 64'h0000_1234_5678_9A40;
    clr(); arvalid_i = 1; arid_i = 4'd3; araddr_i = a; #1;
    checks++;
    if (arready_o !== 1'b1) begin errors++; $display("FAIL rd_arready: got %b required 1", arready_o); end
    tick(); arvalid_i = 0; mc_arready_i = 1; #1;
    checks++;
    if ({mc_arvalid_o, mc_araddr_o} !== {1'b1, 64'h0000_0000_0008_9A40})
      begin errors++; $display("FAIL rd_probe: got v=%b a=%h required v=1 a=%h", mc_arvalid_o, mc_araddr_o, probe(a)); end
    checks++;
    if ({tag_fifo_wren_o, tag_fifo_data_o} !== {1'b1, 1'b0, mtid, a})
      begin errors++; $display("FAIL rd_tag_push: got %b/%h required 1/%h", tag_fifo_wren_o, tag_fifo_data_o, {1'b0, mtid, a}); end
    checks++;
    if ({rob_id_wren_o, rob_id_tid_o, rob_id_o} !== {1'b1, mtid, 4'd3})
      begin errors++; $display("FAIL rd_rob_push: got %b tid=%0d id=%0d required 1 tid=%0d id=3", rob_id_wren_o, rob_id_tid_o, rob_id_o, mtid); end
    tick(); mc_arready_i = 0; mtid++; mcred--; mlast_wr = 0; #1;
    checks++;
    if ({mc_arvalid_o, tag_fifo_wren_o} !== 2'b00)
      begin errors++; $display("FAIL rd_back_idle: got arv=%b wren=%b required 0 0", mc_arvalid_o, tag_fifo_wren_o); end
  endtask

  task automatic test_single_write();
    logic [DW-1:0] d;
    d = {128{4'hA, 4'h5}} >> 0;
    d = {64{8'hA5}};
    clr(); awvalid_i = 1; wvalid_i = 1; awid_i = 4'd5; awaddr_i = 64'h80; wdata_i = d; #1;
    checks++;
    if ({arready_o, awready_o, wready_o} !== 3'b011)
      begin errors++; $display("FAIL wr_ready: got %b required 011", {arready_o, awready_o, wready_o}); end
    tick(); awvalid_i = 0; wvalid_i = 0; mc_arready_i = 1; #1;
    checks++;
    if ({tag_fifo_wren_o, tag_fifo_data_o, mc_araddr_o} !== {1'b1, 1'b1, 4'd0, 64'h80, 64'h80})
      begin errors++; $display("FAIL wr_tag_push: got %b/%h a=%h required 1/%h a=80", tag_fifo_wren_o, tag_fifo_data_o, mc_araddr_o, {1'b1, 4'd0, 64'h80}); end
    checks++;
    if ({wbuffer_wren_o, wbuffer_data_o, rob_id_wren_o} !== {1'b1, d, 1'b0})
      begin errors++; $display("FAIL wr_wbuf_push: got wren=%b rob=%b data=%h", wbuffer_wren_o, rob_id_wren_o, wbuffer_data_o); end
    tick(); mc_arready_i = 0; #1;
    checks++;
    if ({bvalid_o, bid_o} !== {1'b1, 4'd5}) begin errors++; $display("FAIL wr_b: got v=%b id=%0d required v=1 id=5", bvalid_o, bid_o); end
    tick();
    checks++;
    if (bvalid_o !== 1'b1) begin errors++; $display("FAIL wr_b_hold: got %b required 1", bvalid_o); end
    bready_i = 1;
    tick(); bready_i = 0; #1;
    checks++;
    if (bvalid_o !== 1'b0) begin errors++; $display("FAIL wr_b_done: got %b required 0", bvalid_o); end
    mlast_wr = 1;
  endtask

  task automatic test_alternate();
    bit exp_rd;
    logic [AW-1:0] ra, wa;
    logic [TW+AW:0] exp_tag;
    clr();
    for (int g = 0; g < 8; g++) begin
      exp_rd = mlast_wr;
      ra = {$urandom, $urandom}; wa = {$urandom, $urandom};
      arvalid_i = 1; awvalid_i = 1; wvalid_i = 1; araddr_i = ra; awaddr_i = wa;
      arid_i = g[3:0]; awid_i = ~g[3:0]; wdata_i = {16{$urandom}};
      mc_arready_i = 1; bready_i = 1; #1;
      checks++;
      if ({arready_o, awready_o} !== {exp_rd, !exp_rd})
        begin errors++; $display("FAIL alt_grant[%0d]: got ar=%b aw=%b required ar=%b", g, arready_o, awready_o, exp_rd); end
      tick(); arvalid_i = 0; awvalid_i = 0; wvalid_i = 0; #1;
      exp_tag = exp_rd ? {1'b0, mtid, ra} : {1'b1, 4'd0, wa};
      checks++;
      if ({tag_fifo_wren_o, tag_fifo_data_o} !== {1'b1, exp_tag})
        begin errors++; $display("FAIL alt_tag[%0d]: got %b/%h required 1/%h", g, tag_fifo_wren_o, tag_fifo_data_o, exp_tag); end
      tick();
      if (!exp_rd) begin
        checks++;
        if ({bvalid_o, bid_o} !== {1'b1, ~g[3:0]})
          begin errors++; $display("FAIL alt_b[%0d]: got v=%b id=%0d", g, bvalid_o, bid_o); end
        tick();
      end
      if (exp_rd) begin mtid++; mcred--; end
      mlast_wr = !exp_rd;
    end
    clr();
  endtask

  task automatic test_credits();
    logic [TW-1:0] first_tid;
    clr();
    rob_retire_i = 1;
    repeat (20) tick();
    rob_retire_i = 0; mcred = 16;
    first_tid = mtid;
    for (int i = 0; i < 16; i++) begin
      arvalid_i = 1; arid_i = i[3:0]; araddr_i = {$urandom, $urandom}; #1;
      checks++;
      if (arready_o !== 1'b1) begin errors++; $display("FAIL credit_accept[%0d]: got %b required 1", i, arready_o); end
      tick(); arvalid_i = 0; mc_arready_i = 1; #1;
      checks++;
      if (rob_id_tid_o !== mtid) begin errors++; $display("FAIL credit_tid[%0d]: got %0d required %0d", i, rob_id_tid_o, mtid); end
      tick(); mc_arready_i = 0; mtid++; mcred--;
    end
    arvalid_i = 1; #1;
    checks++;
    if (arready_o !== 1'b0) begin errors++; $display("FAIL credit_empty: got %b required 0", arready_o); end
    tick();
    checks++;
    if (arready_o !== 1'b0) begin errors++; $display("FAIL credit_empty2: got %b required 0", arready_o); end
    rob_retire_i = 1;
    tick(); rob_retire_i = 0; #1;
    checks++;
    if (arready_o !== 1'b1) begin errors++; $display("FAIL credit_return: got %b required 1", arready_o); end
    tick(); arvalid_i = 0; mc_arready_i = 1; #1;
    checks++;
    if (rob_id_tid_o !== first_tid) begin errors++; $display("FAIL credit_wrap_tid: got %0d required %0d", rob_id_tid_o, first_tid); end
    tick(); mc_arready_i = 0; mtid++;
    rob_retire_i = 1;
    repeat (16) tick();
    rob_retire_i = 0; mcred = 16;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    wa = {$urandom, $urandom}; d = {16{$urandom}};
    clr(); tag_fifo_afull_i = 1; arvalid_i = 1; awvalid_i = 1; wvalid_i = 1;
    araddr_i = {$urandom, $urandom}; awaddr_i = wa; awid_i = 4'd9; wdata_i = d; #1;
    checks++;
    if ({arready_o, awready_o, wready_o} !== 3'b000)
      begin errors++; $display("FAIL afull_tag: got %b required 000", {arready_o, awready_o, wready_o}); end
    tick(); tag_fifo_afull_i = 0; wbuffer_afull_i = 1; arvalid_i = 0; #1;
    checks++;
    if ({awready_o, wready_o} !== 2'b00) begin errors++; $display("FAIL afull_wbuf: got %b required 00", {awready_o, wready_o}); end
    tick(); wbuffer_afull_i = 0; #1;
    checks++;
    if ({awready_o, wready_o} !== 2'b11) begin errors++; $display("FAIL afull_release: got %b required 11", {awready_o, wready_o}); end
    tick(); awvalid_i = 0; wvalid_i = 0;
    for (int k = 0; k < 5; k++) begin
      tag_fifo_afull_i = k[0]; #1;
      checks++;
      if ({mc_arvalid_o, mc_araddr_o, tag_fifo_wren_o, wbuffer_wren_o} !== {1'b1, probe(wa), 2'b00})
        begin errors++; $display("FAIL stall[%0d]: got v=%b a=%h wren=%b%b required v=1 a=%h 00", k, mc_arvalid_o, mc_araddr_o, tag_fifo_wren_o, wbuffer_wren_o, probe(wa)); end
      tick();
    end
    tag_fifo_afull_i = 1; wbuffer_afull_i = 1; mc_arready_i = 1; #1;
    checks++;
    if ({tag_fifo_wren_o, wbuffer_wren_o, wbuffer_data_o} !== {2'b11, d})
      begin errors++; $display("FAIL stall_push: got wren=%b%b data=%h", tag_fifo_wren_o, wbuffer_wren_o, wbuffer_data_o); end
    tick(); clr(); bready_i = 1; #1;
    checks++;
    if ({bvalid_o, bid_o} !== {1'b1, 4'd9}) begin errors++; $display("FAIL stall_b: got v=%b id=%0d required 1 9", bvalid_o, bid_o); end
    tick(); bready_i = 0;
    mlast_wr = 1;
  endtask

  task automatic test_reset_mid();
    clr(); arvalid_i = 1; arid_i = 4'd7; araddr_i = {$urandom, $urandom}; #1;
    tick(); arvalid_i = 0; #1;
    checks++;
    if (mc_arvalid_o !== 1'b1) begin errors++; $display("FAIL rstmid_probe: got %b required 1", mc_arvalid_o); end
    rst_n = 0; mc_arready_i = 1;
    tick();
    checks++;
    if ({mc_arvalid_o, tag_fifo_wren_o, rob_id_wren_o, wbuffer_wren_o, bvalid_o, mc_araddr_o, tag_fifo_data_o, rob_id_o} !== '0)
      begin errors++; $display("FAIL rstmid_outputs: got arv=%b wren=%b rob=%b a=%h tag=%h required all 0", mc_arvalid_o, tag_fifo_wren_o, rob_id_wren_o, mc_araddr_o, tag_fifo_data_o); end
    rst_n = 1; mc_arready_i = 0;
    mtid = 0; mcred = 16; mlast_wr = 1;
    tick();
    arvalid_i = 1; arid_i = 4'd2; #1;
    tick(); arvalid_i = 0; mc_arready_i = 1; #1;
    checks++;
    if ({rob_id_wren_o, rob_id_tid_o, rob_id_o} !== {1'b1, 4'd0, 4'd2})
      begin errors++; $display("FAIL rstmid_tid: got %b tid=%0d id=%0d required 1 0 2", rob_id_wren_o, rob_id_tid_o, rob_id_o); end
    tick(); mc_arready_i = 0; mtid++; mcred--; mlast_wr = 0;
  endtask

  task automatic test_random();
    int phase;
    bit is_wr, rd_el, wr_el, g_rd, g_wr, alloc;
    logic [IW-1:0] q_id;
    logic [AW-1:0] q_addr;
    logic [DW-1:0] q_data;
    logic [7:0] exp_v, got_v;
    phase = 0; is_wr = 0; q_id = '0; q_addr = '0; q_data = '0;
    clr();
    for (int c = 0; c < 800; c++) begin
      arvalid_i = 1'($urandom_range(0, 1)); awvalid_i = 1'($urandom_range(0, 1));
      wvalid_i = ($urandom_range(0, 3) != 0);
      tag_fifo_afull_i = ($urandom_range(0, 5) == 0); wbuffer_afull_i = ($urandom_range(0, 5) == 0);
      mc_arready_i = ($urandom_range(0, 2) != 0); bready_i = 1'($urandom_range(0, 1));
      rob_retire_i = ($urandom_range(0, 4) == 0);
      arid_i = 4'($urandom); awid_i = 4'($urandom);
      araddr_i = {$urandom, $urandom}; awaddr_i = {$urandom, $urandom}; wdata_i = {16{$urandom}};
      #1;
      g_rd = 0; g_wr = 0;
      if (phase == 0) begin
        rd_el = arvalid_i && (mcred > 0) && !tag_fifo_afull_i;
        wr_el = awvalid_i && wvalid_i && !tag_fifo_afull_i && !wbuffer_afull_i;
        g_rd = rd_el && (!wr_el || mlast_wr);
        g_wr = wr_el && !g_rd;
      end
      alloc = (phase == 1) && !is_wr && mc_arready_i;
      exp_v = {g_rd, g_wr, g_wr, phase == 1, (phase == 1) && mc_arready_i,
               (phase == 1) && is_wr && mc_arready_i, alloc, phase == 2};
      got_v = {arready_o, awready_o, wready_o, mc_arvalid_o, tag_fifo_wren_o,
               wbuffer_wren_o, rob_id_wren_o, bvalid_o};
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL rand_ctrl[%0d]: got %b required %b", c, got_v, exp_v); end
      if (phase == 1) begin
        checks++;
        if (mc_araddr_o !== probe(q_addr)) begin errors++; $display("FAIL rand_addr[%0d]: got %h required %h", c, mc_araddr_o, probe(q_addr)); end
        if (mc_arready_i) begin
          checks++;
          if (tag_fifo_data_o !== {is_wr, is_wr ? 4'd0 : mtid, q_addr} ||
              (is_wr ? (wbuffer_data_o !== q_data) : ({rob_id_tid_o, rob_id_o} !== {mtid, q_id})))
            begin errors++; $display("FAIL rand_push[%0d]: got tag=%h tid=%0d id=%0d required tag=%h tid=%0d id=%0d", c, tag_fifo_data_o, rob_id_tid_o, rob_id_o, {is_wr, is_wr ? 4'd0 : mtid, q_addr}, mtid, q_id); end
        end
      end
      if (phase == 2) begin
        checks++;
        if (bid_o !== q_id) begin errors++; $display("FAIL rand_bid[%0d]: got %0d required %0d", c, bid_o, q_id); end
      end
      if (alloc && !rob_retire_i) mcred--;
      else if (!alloc && rob_retire_i && mcred < 16) mcred++;
      if (alloc) mtid++;
      case (phase)
        0: if (g_rd || g_wr) begin
             phase = 1; is_wr = g_wr; mlast_wr = g_wr;
             q_id = g_rd ? arid_i : awid_i;
             q_addr = g_rd ? araddr_i : awaddr_i;
             if (g_wr) q_data = wdata_i;
           end
        1: if (mc_arready_i) phase = is_wr ? 2 : 0;
        default: if (bready_i) phase = 0;
      endcase
      tick();
    end
    clr();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_alternate();
    test_credits();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
